// File: rtl/tile_stream_reader_if.sv
//------------------------------------------------------------------------------
// tile_stream_reader_if : sample stream from the tile reader to the DWT engine
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface tile_stream_reader_if;
  logic [8:0] smp_data;
  logic       smp_vld;
  logic       smp_rdy;
  logic [1:0] smp_comp;
  logic       smp_sol;
  logic       smp_eot;

  modport master (
    output smp_data, smp_vld, smp_comp, smp_sol, smp_eot,
    input  smp_rdy
  );

  modport slave (
    input  smp_data, smp_vld, smp_comp, smp_sol, smp_eot,
    output smp_rdy
  );
endinterface

`default_nettype wire

// File: rtl/tile_stream_reader.sv
//------------------------------------------------------------------------------
// tile_stream_reader : drains a ping-pong tile bank into a plane-ordered sample
//                      stream; optional DC level shift via TSR_DC_SHIFT_EN
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tile_stream_reader #(
  parameter int RD_LAT      = 1,
  parameter int PLANE_WORDS = 4096,
  parameter int NUM_PLANES  = 3
) (
  input  wire                  clk_dwt,
  input  wire                  rst,
  input  wire                  rst_syn,
  input  wire                  start,
  output logic [13:0]          addrb_o1,
  output logic [13:0]          addrb_o2,
  output logic                 enb_o1,
  output logic                 enb_o2,
  input  wire  [16:0]          doutb_o1,
  input  wire  [16:0]          doutb_o2,
  tile_stream_reader_if.master smp,
  output logic                 bank_free,
  output logic                 busy,
  output logic                 ovf_err
);

  localparam int              c_PW         = $clog2(2 * PLANE_WORDS);
  localparam logic [13:0]     c_LAST_ADDR  = 14'(PLANE_WORDS * NUM_PLANES - 1);
  localparam logic [c_PW-1:0] c_PLANE_LAST = c_PW'(2 * PLANE_WORDS - 1);
  localparam logic [1:0]      c_LAST_COMP  = 2'(NUM_PLANES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_start_d;
  logic              r_pending;
  logic              r_ovf;
  logic              r_bank;
  logic [13:0]       r_addr;
  logic [RD_LAT-1:0] r_rd_pipe;
  logic [15:0]       r_fifo [4];
  logic [1:0]        r_wptr;
  logic [1:0]        r_rptr;
  logic [2:0]        r_cnt;
  logic [c_PW-1:0]   r_pcnt;
  logic [1:0]        r_comp;

  logic        w_rise;
  logic [2:0]  w_inflight;
  logic [3:0]  w_occ;
  logic        w_rd_go;
  logic        w_ret;
  logic [15:0] w_rdata;
  logic [15:0] w_head;
  logic        w_vld;
  logic        w_acc;
  logic        w_pop;
  logic        w_plane_end;
  logic        w_last_smp;
  logic [7:0]  w_byte;
  logic [8:0]  w_sdata;
  logic        w_unused;

  assign w_unused = ^{doutb_o1[16], doutb_o2[16]};

  assign w_rise = start & ~r_start_d;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_inflight = w_inflight + {2'b00, r_rd_pipe[i]};
    end
  end

  // Reads in flight already own a FIFO slot, so the FIFO can never overflow.
  assign w_occ   = {1'b0, r_cnt} + {1'b0, w_inflight};
  assign w_rd_go = (r_state == S_READ) && (w_occ < 4'd4);
  assign w_ret   = r_rd_pipe[RD_LAT-1];
  assign w_rdata = r_bank ? doutb_o2[15:0] : doutb_o1[15:0];

  assign w_head      = r_fifo[r_rptr];
  assign w_vld       = (r_cnt != 3'd0);
  assign w_acc       = w_vld && smp.smp_rdy;
  assign w_pop       = w_acc && r_pcnt[0];
  assign w_plane_end = (r_pcnt == c_PLANE_LAST);
  assign w_last_smp  = w_plane_end && (r_comp == c_LAST_COMP);

  always_comb begin
    w_byte = r_pcnt[0] ? w_head[15:8] : w_head[7:0];
`ifdef TSR_DC_SHIFT_EN
    w_sdata = {1'b0, w_byte} - 9'd128;
`else
    w_sdata = {1'b0, w_byte};
`endif
  end

  assign enb_o1   = w_rd_go && !r_bank;
  assign enb_o2   = w_rd_go &&  r_bank;
  assign addrb_o1 = r_bank ? 14'd0 : r_addr;
  assign addrb_o2 = r_bank ? r_addr : 14'd0;

  assign smp.smp_vld  = w_vld;
  assign smp.smp_data = w_vld ? w_sdata : 9'd0;
  assign smp.smp_comp = w_vld ? r_comp : 2'd0;
  assign smp.smp_sol  = w_vld && (r_pcnt[6:0] == 7'd0);
  assign smp.smp_eot  = w_vld && w_last_smp;
  assign ovf_err      = r_ovf;

  always_ff @(posedge clk_dwt or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else if (rst_syn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    bank_free   = 1'b0;
    busy        = (r_state != S_IDLE);
    unique case (r_state)
      S_IDLE:  if (w_rise) w_state_nxt = S_READ;
      S_READ:  if (w_rd_go && (r_addr == c_LAST_ADDR)) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_acc && w_last_smp) w_state_nxt = S_DONE;
      S_DONE: begin
        bank_free   = 1'b1;
        w_state_nxt = (r_pending || w_rise) ? S_READ : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_dwt or negedge rst) begin
    if (!rst) begin
      r_start_d <= 1'b0;
      r_pending <= 1'b0;
      r_ovf     <= 1'b0;
      r_bank    <= 1'b0;
      r_addr    <= '0;
      r_rd_pipe <= '0;
    end else if (rst_syn) begin
      r_start_d <= 1'b0;
      r_pending <= 1'b0;
      r_ovf     <= 1'b0;
      r_bank    <= 1'b0;
      r_addr    <= '0;
      r_rd_pipe <= '0;
    end else begin
      r_start_d <= start;
      // A start landing in DONE is folded into the immediate restart.
      if (r_state == S_DONE) begin
        r_pending <= r_pending && w_rise;
      end else if (w_rise && (r_state != S_IDLE)) begin
        if (r_pending) r_ovf <= 1'b1;
        else           r_pending <= 1'b1;
      end
      if (r_state == S_DONE) begin
        r_bank <= ~r_bank;
        r_addr <= '0;
      end else if (w_rd_go) begin
        r_addr <= r_addr + 14'd1;
      end
      r_rd_pipe[0] <= w_rd_go;
      for (int i = 1; i < RD_LAT; i++) begin
        r_rd_pipe[i] <= r_rd_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk_dwt) begin
    if (w_ret) r_fifo[r_wptr] <= w_rdata;
  end

  always_ff @(posedge clk_dwt or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_pcnt <= '0;
      r_comp <= '0;
    end else if (rst_syn) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_pcnt <= '0;
      r_comp <= '0;
    end else begin
      if (w_ret) r_wptr <= r_wptr + 2'd1;
      if (w_pop) r_rptr <= r_rptr + 2'd1;
      case ({w_ret, w_pop})
        2'b10:   r_cnt <= r_cnt + 3'd1;
        2'b01:   r_cnt <= r_cnt - 3'd1;
        default: r_cnt <= r_cnt;
      endcase
      // Plane/sample counters wrap to zero at end of tile, ready for the next.
      if (w_acc) begin
        if (w_plane_end) begin
          r_pcnt <= '0;
          r_comp <= w_last_smp ? 2'd0 : r_comp + 2'd1;
        end else begin
          r_pcnt <= r_pcnt + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tile_stream_reader.sv
//------------------------------------------------------------------------------
// tb_tile_stream_reader : scoreboard bench for tile_stream_reader
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_tile_stream_reader;
  localparam int RD_LAT     = 1;
  localparam int TILE_WORDS = 12288;
  localparam int TILE_SMP   = 24576;

  typedef struct packed {
    logic [8:0] data;
    logic [1:0] comp;
    logic       sol;
    logic       eot;
  } smp_t;

  logic        clk_dwt = 1'b0;
  logic        rst     = 1'b0;
  logic        rst_syn = 1'b0;
  logic        start   = 1'b0;
  logic [13:0] addrb_o1, addrb_o2;
  logic        enb_o1, enb_o2;
  logic [16:0] doutb_o1, doutb_o2;
  logic        bank_free, busy, ovf_err;

  tile_stream_reader_if smp();

  tile_stream_reader #(.RD_LAT(RD_LAT)) dut (
    .clk_dwt  (clk_dwt),
    .rst      (rst),
    .rst_syn  (rst_syn),
    .start    (start),
    .addrb_o1 (addrb_o1),
    .addrb_o2 (addrb_o2),
    .enb_o1   (enb_o1),
    .enb_o2   (enb_o2),
    .doutb_o1 (doutb_o1),
    .doutb_o2 (doutb_o2),
    .smp      (smp),
    .bank_free(bank_free),
    .busy     (busy),
    .ovf_err  (ovf_err)
  );

  always #5 clk_dwt = ~clk_dwt;

  logic [16:0] mem1 [TILE_WORDS];
  logic [16:0] mem2 [TILE_WORDS];
  logic [16:0] p1 [RD_LAT];
  logic [16:0] p2 [RD_LAT];

  always @(posedge clk_dwt) begin
    p1[0] <= enb_o1 ? mem1[addrb_o1] : 17'h0;
    p2[0] <= enb_o2 ? mem2[addrb_o2] : 17'h0;
    for (int i = 1; i < RD_LAT; i++) begin
      p1[i] <= p1[i-1];
      p2[i] <= p2[i-1];
    end
  end
  assign doutb_o1 = p1[RD_LAT-1];
  assign doutb_o2 = p2[RD_LAT-1];

  int   tests = 0, errors = 0;
  int   cyc = 0;
  int   acc_cnt = 0, eot_cnt = 0, bf_cnt = 0;
  int   eot_cyc = 0, bf_cyc = 0;
  int   first_vld_cyc = -1, first_enb_cyc = -1;
  int   idle_seen = 0;
  bit   watch_busy = 0;
  bit   rdy_mode = 0;
  bit   exp_bank = 0;
  int   exp_rd_addr = 0;
  smp_t exp_q[$];
  smp_t held;
  bit   prev_stall = 0;

  always @(posedge clk_dwt) cyc++;

  initial begin
    smp.smp_rdy = 1'b0;
    forever begin
      @(posedge clk_dwt);
      #1;
      smp.smp_rdy = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  function automatic smp_t model(input logic [16:0] w, input int s);
    smp_t       r;
    logic [7:0] b;
    b = s[0] ? w[15:8] : w[7:0];
`ifdef TSR_DC_SHIFT_EN
    r.data = 9'(int'(b) - 128);
`else
    r.data = {1'b0, b};
`endif
    r.comp = 2'(s / 8192);
    r.sol  = ((s % 128) == 0);
    r.eot  = (s == TILE_SMP - 1);
    return r;
  endfunction

  task automatic push_tile(input bit bank);
    for (int s = 0; s < TILE_SMP; s++) begin
      exp_q.push_back(model(bank ? mem2[s/2] : mem1[s/2], s));
    end
  endtask

  // Scoreboard monitor: sample stream, stall stability, read port sequence.
  always @(negedge clk_dwt) begin
    smp_t got;
    smp_t exp;
    logic [29:0] rd_got, rd_exp;
    got = '{smp.smp_data, smp.smp_comp, smp.smp_sol, smp.smp_eot};
    if (smp.smp_vld && first_vld_cyc < 0) first_vld_cyc = cyc;
    if (prev_stall) begin
      tests++;
      if (!smp.smp_vld || got !== held) begin
        errors++;
        $display("FAIL stall_hold: vld=%0b got %h required %h", smp.smp_vld, got, held);
      end
    end
    if (smp.smp_vld && smp.smp_rdy) begin
      tests++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sample[%0d]: got %h but none expected", acc_cnt, got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL sample[%0d]: got %h required %h", acc_cnt, got, exp);
        end
      end
      acc_cnt++;
      if (got.eot) begin
        eot_cnt++;
        eot_cyc = cyc;
      end
    end
    prev_stall = smp.smp_vld && !smp.smp_rdy;
    held = got;
    if (bank_free) begin
      bf_cnt++;
      bf_cyc = cyc;
    end
    if (enb_o1 || enb_o2) begin
      if (first_enb_cyc < 0) first_enb_cyc = cyc;
      tests++;
      rd_got = {enb_o1, enb_o2, addrb_o1, addrb_o2};
      rd_exp = exp_bank ? {2'b01, 14'd0, 14'(exp_rd_addr)} : {2'b10, 14'(exp_rd_addr), 14'd0};
      if (rd_got !== rd_exp) begin
        errors++;
        $display("FAIL read_port: got %h required %h", rd_got, rd_exp);
      end
      exp_rd_addr++;
      if (exp_rd_addr == TILE_WORDS) begin
        exp_rd_addr = 0;
        exp_bank = ~exp_bank;
      end
    end
    if (watch_busy && !busy) idle_seen++;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  function automatic int cnt_sel(input int which);
    case (which)
      0:       return eot_cnt;
      1:       return acc_cnt;
      default: return bf_cnt;
    endcase
  endfunction

  task automatic wait_for(input string name, input int which, input int target, input int budget);
    int k = 0;
    while (cnt_sel(which) < target && k < budget) begin
      @(posedge clk_dwt);
      k++;
    end
    #1;
    tests++;
    if (cnt_sel(which) < target) begin
      errors++;
      $display("FAIL %s: timeout, count %0d required %0d", name, cnt_sel(which), target);
    end
  endtask

  task automatic pulse_start(input int width);
    start = 1'b1;
    repeat (width) begin
      @(posedge clk_dwt);
      #1;
    end
    start = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_dwt);
      #1;
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({addrb_o1, addrb_o2, enb_o1, enb_o2, smp.smp_data, smp.smp_vld,
                smp.smp_comp, smp.smp_sol, smp.smp_eot, bank_free, busy, ovf_err});
  endfunction

  initial begin
    int t0, t1_eot, bf_before, base;
    for (int k = 0; k < TILE_WORDS; k++) begin
      logic [7:0] lo;
      lo = k[7:0];
      mem1[k] = {1'b1, lo + 8'd1, lo};
      mem2[k] = {1'b1, 8'(k * 3), 8'(k >> 5)};
    end

    step(3);
    check("reset_async_outputs", all_outs(), 64'd0);
    rst = 1'b1;
    step(2);
    check("reset_idle_outputs", all_outs(), 64'd0);

    // Tile 1 from bank 1, ready held high.
    first_vld_cyc = -1;
    first_enb_cyc = -1;
    push_tile(1'b0);
    t0 = cyc;
    pulse_start(1);
    wait_for("tile1_first_sample", 1, 1, 20);
    check("tile1_first_enb_latency", 64'(first_enb_cyc - t0), 64'd1);
    check("tile1_first_vld_latency", 64'(first_vld_cyc - t0), 64'(2 + RD_LAT));
    watch_busy = 1;

    wait_for("tile1_mid", 1, 1000, 2000);
    push_tile(1'b1);
    pulse_start(2);

    wait_for("tile1_eot", 0, 1, 30000);
    t1_eot = eot_cyc;
    check("tile1_eot_cycle", 64'(t1_eot - t0), 64'(TILE_SMP + 1 + RD_LAT));
    rdy_mode = 1;
    wait_for("tile1_bank_free", 2, 1, 5);
    check("tile1_bank_free_cycle", 64'(bf_cyc - t1_eot), 64'd1);

    // Tile 2 from bank 2 under random ready; pending start then a lost one.
    step(200);
    check("ovf_clear_before", 64'(ovf_err), 64'd0);
    push_tile(1'b0);
    pulse_start(1);
    step(50);
    pulse_start(1);
    step(3);
    check("ovf_set", 64'(ovf_err), 64'd1);

    wait_for("tile2_eot", 0, 2, 60000);
    rdy_mode = 0;
    wait_for("tile2_bank_free", 2, 2, 5);

    // Tile 3 aborted by the synchronous clear.
    wait_for("tile3_sample5000", 1, 2 * TILE_SMP + 5000, 6000);
    check("ovf_sticky", 64'(ovf_err), 64'd1);
    check("no_idle_gap", 64'(idle_seen), 64'd0);
    watch_busy = 0;
    bf_before = bf_cnt;
    rst_syn = 1'b1;
    step(1);
    rst_syn = 1'b0;
    check("rst_syn_outputs", all_outs(), 64'd0);
    exp_q.delete();
    exp_rd_addr = 0;
    exp_bank = 0;
    step(5);
    check("abort_no_bank_free", 64'(bf_cnt), 64'(bf_before));
    check("abort_idle", 64'({busy, ovf_err, smp.smp_vld}), 64'd0);

    // Tile 4 restarts on bank 1 at address 0.
    first_vld_cyc = -1;
    first_enb_cyc = -1;
    base = acc_cnt;
    push_tile(1'b0);
    t0 = cyc;
    pulse_start(1);
    wait_for("tile4_samples", 1, base + 300, 400);
    check("tile4_first_enb_latency", 64'(first_enb_cyc - t0), 64'd1);
    check("tile4_first_vld_latency", 64'(first_vld_cyc - t0), 64'(2 + RD_LAT));
    rst_syn = 1'b1;
    step(1);
    rst_syn = 1'b0;
    exp_q.delete();
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

`default_nettype wire
